// File: rtl/debounce_edge_pkg.sv
// Shared types and constants for the debounce_edge block: per-channel FSM state
// encoding and the input synchroniser depth.
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam int SYNC_STAGES = 2;

    // The debounced level stays high while a candidate low is still being qualified.
    function automatic logic is_high(input deb_state_t s);
        return (s == S_HIGH) || (s == S_WAIT_LOW);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: a four-state FSM with a saturating qualification counter
// that emits registered one-cycle rise/fall pulses when a new level is accepted.
module debounce_chan
    import debounce_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit PULSE_ON_FALL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_set
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_t    state, state_next;
    logic [CW-1:0] count, count_next;
    logic          fall_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOW;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            rise  <= rise_set;
            fall  <= fall_set;
        end
    end

    assign level = is_high(state);

    // count holds the number of consecutive candidate samples already taken, so
    // the edge taking sample DEBOUNCE_CYCLES is the one where count has reached LAST.
    always_comb begin
        state_next = state;
        count_next = count;
        rise_set   = 1'b0;
        fall_set   = 1'b0;
        case (state)
            S_LOW: begin
                if (x) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = S_HIGH;
                        rise_set   = 1'b1;
                    end else begin
                        state_next = S_WAIT_HIGH;
                        count_next = CW'(1);
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (!x) begin
                    state_next = S_LOW;
                    count_next = '0;
                end else if (count >= LAST) begin
                    state_next = S_HIGH;
                    count_next = '0;
                    rise_set   = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            S_HIGH: begin
                if (!x) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = S_LOW;
                        fall_set   = PULSE_ON_FALL;
                    end else begin
                        state_next = S_WAIT_LOW;
                        count_next = CW'(1);
                    end
                end
            end
            S_WAIT_LOW: begin
                if (x) begin
                    state_next = S_HIGH;
                    count_next = '0;
                end else if (count >= LAST) begin
                    state_next = S_LOW;
                    count_next = '0;
                    fall_set   = PULSE_ON_FALL;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = S_LOW;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/debounce_edge.sv
// Multi-channel debouncer with edge pulses. Define DEBOUNCE_EDGE_SYNC_EN to put a
// two-flop synchroniser ahead of each channel FSM (adds two cycles of latency).
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit PULSE_ON_FALL   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_rise
);

    logic [N_CH-1:0] x_vec;
    logic [N_CH-1:0] rise_set;

`ifdef DEBOUNCE_EDGE_SYNC_EN
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign x_vec = sync_q[SYNC_STAGES-1];
`else
    assign x_vec = in;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .PULSE_ON_FALL  (PULSE_ON_FALL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .x       (x_vec[i]),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .rise_set(rise_set[i])
        );
    end

    // Registered from the channels' next-cycle rise values so it lines up with rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_rise <= 1'b0;
        end else begin
            any_rise <= |rise_set;
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: D=4 main instance, a D=4 no-fall-pulse
// instance sharing its inputs, and a D=1 instance checked as a plain one-shot.
module tb_debounce_edge;

`ifdef DEBOUNCE_EDGE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_main, in_one;
    logic [3:0] level_m, rise_m, fall_m;
    logic [3:0] level_n, rise_n, fall_n;
    logic [3:0] level_o, rise_o, fall_o;
    logic       any_m, any_n, any_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_edge #(.N_CH(4), .DEBOUNCE_CYCLES(D), .PULSE_ON_FALL(1'b1)) u_main (
        .clk(clk), .rst(rst), .in(in_main),
        .level(level_m), .rise(rise_m), .fall(fall_m), .any_rise(any_m));

    debounce_edge #(.N_CH(4), .DEBOUNCE_CYCLES(D), .PULSE_ON_FALL(1'b0)) u_nofall (
        .clk(clk), .rst(rst), .in(in_main),
        .level(level_n), .rise(rise_n), .fall(fall_n), .any_rise(any_n));

    debounce_edge #(.N_CH(4), .DEBOUNCE_CYCLES(1), .PULSE_ON_FALL(1'b1)) u_one (
        .clk(clk), .rst(rst), .in(in_one),
        .level(level_o), .rise(rise_o), .fall(fall_o), .any_rise(any_o));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] v);
        in_main = v;
        tick();
    endtask

    task automatic checkMain(input string tag, input logic [3:0] lv, input logic [3:0] rs,
                             input logic [3:0] fl);
        checkOutput({tag, "_level"},   32'(level_m), 32'(lv));
        checkOutput({tag, "_rise"},    32'(rise_m),  32'(rs));
        checkOutput({tag, "_fall"},    32'(fall_m),  32'(fl));
        checkOutput({tag, "_anyrise"}, 32'(any_m),   32'(|rs));
        checkOutput({tag, "_nf_level"}, 32'(level_n), 32'(lv));
        checkOutput({tag, "_nf_rise"},  32'(rise_n),  32'(rs));
        checkOutput({tag, "_nf_fall"},  32'(fall_n),  32'(0));
    endtask

    // Hold v for n cycles starting from settled level lv0; changed channels settle together.
    task automatic holdPhase(input string tag, input logic [3:0] v, input int n, input logic [3:0] lv0);
        logic [3:0] chg;
        chg = v ^ lv0;
        for (int t = 1; t <= n; t++) begin
            applyStimulus(v);
            checkMain(tag,
                      (t >= D + L) ? v : lv0,
                      (t == D + L) ? (chg & v) : 4'b0000,
                      (t == D + L) ? (chg & ~v) : 4'b0000);
        end
    endtask

    logic [3:0] one_vecs [12];
    logic [5:0] bounce;

    initial begin
        rst     = 1'b1;
        in_main = 4'b0000;
        in_one  = 4'b0000;
        tick();
        tick();
        checkMain("reset", 4'b0000, 4'b0000, 4'b0000);
        checkOutput("reset_one_level", 32'(level_o), 32'(0));
        rst = 1'b0;

        // Clean press and release on channel 0.
        holdPhase("t1r", 4'b0001, 10, 4'b0000);
        holdPhase("t1f", 4'b0000, D + L + 2, 4'b0001);

        // Short glitch on channel 1 is rejected, then a bouncing press is accepted once.
        for (int t = 1; t <= 3; t++) begin
            applyStimulus(4'b0010);
            checkMain("t2g", 4'b0000, 4'b0000, 4'b0000);
        end
        for (int t = 1; t <= 8; t++) begin
            applyStimulus(4'b0000);
            checkMain("t2q", 4'b0000, 4'b0000, 4'b0000);
        end
        bounce = 6'b111101;
        for (int t = 1; t <= 10 + L; t++) begin
            applyStimulus({2'b00, (t <= 6) ? bounce[t-1] : 1'b1, 1'b0});
            checkMain("t2b", (t >= 6 + L) ? 4'b0010 : 4'b0000,
                      (t == 6 + L) ? 4'b0010 : 4'b0000, 4'b0000);
        end
        holdPhase("t2f", 4'b0000, D + L + 2, 4'b0010);

        // Release on channel 2, including the no-fall-pulse instance.
        holdPhase("t3r", 4'b0100, D + L + 2, 4'b0000);
        holdPhase("t3f", 4'b0000, 6 + L, 4'b0100);

        // Reset in the middle of qualifying channel 3, then re-qualify with input still high.
        for (int t = 1; t <= 2 + L; t++) begin
            applyStimulus(4'b1000);
            checkMain("t4pre", 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b1;
        applyStimulus(4'b1000);
        checkMain("t4rst", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        holdPhase("t4r", 4'b1000, D + L + 2, 4'b0000);
        holdPhase("t4f", 4'b0000, D + L + 2, 4'b1000);

        // All channels together, held well past qualification.
        holdPhase("t5r", 4'b1111, D + L + 4, 4'b0000);
        holdPhase("t5f", 4'b0000, D + L + 4, 4'b1111);

        // D=1 instance behaves as a registered one-shot on each channel.
        one_vecs = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b1111, 4'b0000,
                     4'b0101, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
        for (int t = 1; t <= 12; t++) begin
            logic [3:0] cur, prev;
            in_one = one_vecs[t-1];
            tick();
            cur  = (t - L >= 1) ? one_vecs[t-L-1] : 4'b0000;
            prev = (t - L >= 2) ? one_vecs[t-L-2] : 4'b0000;
            checkOutput("t6_level",   32'(level_o), 32'(cur));
            checkOutput("t6_rise",    32'(rise_o),  32'(cur & ~prev));
            checkOutput("t6_fall",    32'(fall_o),  32'(~cur & prev));
            checkOutput("t6_anyrise", 32'(any_o),   32'(|(cur & ~prev)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
